// File: rtl/key_conditioner.sv
// -----------------------------------------------------------------------------
// key_conditioner
//   Conditions raw pushbuttons for the processor's key inputs. Each channel
//   runs a 2-flop synchronizer, a debounce counter and a 4-state FSM. The
//   channel produces a clean debounced level and one-cycle press and release
//   strobes, so one physical press causes exactly one action.
//
//   Optional feature (compile-time macro KEY_AUTOREPEAT_EN):
//     While a key is held, key_press pulses again after REPEAT_DELAY cycles.
//     It then pulses once every REPEAT_PERIOD cycles until the key is released.
//     When the macro is undefined, no repeat logic is built.
//
// Ports
//   clk          system clock, all state on posedge
//   rst          asynchronous active-high reset
//   key_raw      raw asynchronous buttons, 1 = pressed
//   key_level    debounced key state, 1 = held
//   key_press    one-cycle strobe on accepted press (plus repeats if enabled)
//   key_release  one-cycle strobe on accepted release
//   key_busy     1 while any channel is qualifying a level change (status)
// -----------------------------------------------------------------------------
module key_conditioner #(
  parameter int NUM_KEYS        = 5,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                key_busy
);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > (2 ** CNT_W) - 1 ||
      REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("key_conditioner: illegal parameter set");
  end

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1, sync2;
  state_t              state      [NUM_KEYS];
  state_t              state_next [NUM_KEYS];
  logic [CNT_W-1:0]    cnt        [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_next   [NUM_KEYS];
  logic [NUM_KEYS-1:0] level_next, press_next, release_next, busy_vec;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RPT_W   = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0]    rpt      [NUM_KEYS];
  logic [RPT_W-1:0]    rpt_next [NUM_KEYS];
  // Set once the first (delayed) repeat has fired; later repeats use the period.
  logic [NUM_KEYS-1:0] repeating, repeating_next;
`endif

  // Next-state and output logic for every channel.
  always_comb begin
    for (int i = 0; i < NUM_KEYS; i++) begin
      // NOTE: every variable gets a default before the case so no path can
      // leave one unassigned and infer a latch.
      state_next[i]   = state[i];
      cnt_next[i]     = cnt[i];
      level_next[i]   = key_level[i];
      press_next[i]   = 1'b0;
      release_next[i] = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_next[i]       = '0;
      repeating_next[i] = 1'b0;
`endif

      case (state[i])
        IDLE: begin
          if (sync2[i]) begin
            state_next[i] = PRESS_WAIT;
            cnt_next[i]   = '0;
          end
        end

        PRESS_WAIT: begin
          if (!sync2[i]) begin
            state_next[i] = IDLE;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_next[i] = HELD;
            cnt_next[i]   = '0;
            level_next[i] = 1'b1;
            press_next[i] = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end

        HELD: begin
          if (!sync2[i]) begin
            state_next[i] = RELEASE_WAIT;
            cnt_next[i]   = '0;
          end
`ifdef KEY_AUTOREPEAT_EN
          else if ((!repeating[i] && rpt[i] == DELAY_LAST) ||
                   ( repeating[i] && rpt[i] == PERIOD_LAST)) begin
            press_next[i]     = 1'b1;
            repeating_next[i] = 1'b1;
          end else begin
            rpt_next[i]       = rpt[i] + RPT_W'(1);
            repeating_next[i] = repeating[i];
          end
`endif
        end

        RELEASE_WAIT: begin
          if (sync2[i]) begin
            state_next[i] = HELD;
            cnt_next[i]   = '0;
          end else if (cnt[i] == CNT_LAST) begin
            state_next[i]   = IDLE;
            cnt_next[i]     = '0;
            level_next[i]   = 1'b0;
            release_next[i] = 1'b1;
          end else begin
            cnt_next[i] = cnt[i] + CNT_W'(1);
          end
        end

        default: begin
          state_next[i] = IDLE;
          cnt_next[i]   = '0;
        end
      endcase

      busy_vec[i] = (state[i] == PRESS_WAIT) || (state[i] == RELEASE_WAIT);
    end
  end

  // Derived from the state registers, so reset clears it without a clock edge.
  assign key_busy = |busy_vec;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1       <= '0;
      sync2       <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      // NOTE: the per-channel arrays are ordinary control registers, not RAM,
      // so each element is reset so that in-flight transitions abort.
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
`ifdef KEY_AUTOREPEAT_EN
        rpt[i]       <= '0;
        repeating[i] <= 1'b0;
`endif
      end
    end else begin
      // NOTE: non-blocking assignments make all flops sample together, so
      // sync2 receives the old value of sync1 and forms a real two-stage chain.
      sync1       <= key_raw;
      sync2       <= sync1;
      key_level   <= level_next;
      key_press   <= press_next;
      key_release <= release_next;
      for (int i = 0; i < NUM_KEYS; i++) begin
        state[i] <= state_next[i];
        cnt[i]   <= cnt_next[i];
`ifdef KEY_AUTOREPEAT_EN
        rpt[i]       <= rpt_next[i];
        repeating[i] <= repeating_next[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// -----------------------------------------------------------------------------
// tb_key_conditioner
//   Self-checking bench for key_conditioner (DEBOUNCE_CYCLES=8, REPEAT_DELAY=20,
//   REPEAT_PERIOD=6, NUM_KEYS=5). A behavioural model compares against every
//   output on every cycle. The model works from these rules:
//     - a level change is accepted after the synchronized input has disagreed
//       with the level for DEBOUNCE_CYCLES+1 consecutive samples;
//     - a repeat press fires after REPEAT_DELAY, REPEAT_PERIOD, ... cycles of
//       uninterrupted hold.
//   Directed scenarios also check strobe counts and strobe timing.
//   Build with +define+KEY_AUTOREPEAT_EN to cover the repeat feature.
// -----------------------------------------------------------------------------
module tb_key_conditioner;

  localparam int NK = 5;
  localparam int DB = 8;
  localparam int CW = 16;
  localparam int RD = 20;
  localparam int RP = 6;

`ifdef KEY_AUTOREPEAT_EN
  localparam int HOLD60_PRESSES = 7;
  localparam int HOLD60_LAST    = 60;
`else
  localparam int HOLD60_PRESSES = 1;
  localparam int HOLD60_LAST    = 10;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] key_raw;
  logic [NK-1:0] key_level, key_press, key_release;
  logic          key_busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int cyc0   = 0;

  // Reference model state
  logic [NK-1:0] m_s1, m_s2, m_level, m_press, m_release;
  logic          m_busy;
  int            m_run  [NK];   // consecutive samples disagreeing with level
  int            m_held [NK];   // consecutive cycles held steady at level 1

  // Event log for directed checks
  int press_cnt [NK];
  int release_cnt [NK];
  int press_cyc [NK];
  int release_cyc [NK];
  bit busy_seen;

  key_conditioner #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB),
    .CNT_W          (CW),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_busy   (key_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_level = '0; m_press = '0; m_release = '0; m_busy = 1'b0;
    for (int k = 0; k < NK; k++) begin
      m_run[k]  = 0;
      m_held[k] = 0;
    end
  endtask

  // One clock edge of the specified behaviour.
  task automatic model_edge();
    logic [NK-1:0] s;
    s    = m_s2;
    m_s2 = m_s1;
    m_s1 = key_raw;
    m_press   = '0;
    m_release = '0;
    m_busy    = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (s[k] != m_level[k]) begin
        m_run[k]++;
        m_held[k] = 0;
        if (m_run[k] == DB + 1) begin
          m_level[k] = s[k];
          m_run[k]   = 0;
          if (s[k]) m_press[k] = 1'b1;
          else      m_release[k] = 1'b1;
        end
      end else begin
        if (m_run[k] == 0 && m_level[k]) begin
          m_held[k]++;
`ifdef KEY_AUTOREPEAT_EN
          if (m_held[k] >= RD && ((m_held[k] - RD) % RP) == 0) m_press[k] = 1'b1;
`endif
        end else begin
          m_held[k] = 0;
        end
        m_run[k] = 0;
      end
      if (m_run[k] != 0) m_busy = 1'b1;
    end
  endtask

  task automatic clear_log();
    busy_seen = 1'b0;
    for (int k = 0; k < NK; k++) begin
      press_cnt[k]   = 0;
      release_cnt[k] = 0;
      press_cyc[k]   = -1;
      release_cyc[k] = -1;
    end
  endtask

  // Advance one clock, update the model, compare at the falling edge.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge();
    @(negedge clk);
    check("key_level",   key_level,   m_level);
    check("key_press",   key_press,   m_press);
    check("key_release", key_release, m_release);
    check("key_busy",    key_busy,    m_busy);
    if (key_busy === 1'b1) busy_seen = 1'b1;
    for (int k = 0; k < NK; k++) begin
      if (key_press[k] === 1'b1)   begin press_cnt[k]++;   press_cyc[k]   = cyc; end
      if (key_release[k] === 1'b1) begin release_cnt[k]++; release_cyc[k] = cyc; end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Mark the next clock edge as cycle 0 of a scenario.
  task automatic mark();
    cyc0 = cyc + 1;
    clear_log();
  endtask

  initial begin
    // Reset with all keys held: outputs stay 0, then one press each after release.
    rst = 1'b1;
    key_raw = '1;
    model_reset();
    clear_log();
    run(3);
    rst = 1'b0;
    mark();
    run(15);
    for (int k = 0; k < NK; k++) begin
      check("rst_press_count", press_cnt[k], 1);
      check("rst_press_cycle", press_cyc[k] - cyc0, 10);
    end
    check("rst_level_all", key_level, 5'b11111);
    key_raw = '0;
    run(15);

    // Clean press and release on key 2.
    key_raw = 5'b00100;
    mark();
    run(30);
    check("k2_press_count", press_cnt[2], 1);
    check("k2_press_cycle", press_cyc[2] - cyc0, 10);
    check("k2_level", key_level[2], 1'b1);
    key_raw = '0;
    mark();
    run(15);
    check("k2_release_count", release_cnt[2], 1);
    check("k2_release_cycle", release_cyc[2] - cyc0, 10);

    // Bounce on key 0: 3 high / 2 low five times, then stable high.
    clear_log();
    for (int r = 0; r < 5; r++) begin
      key_raw[0] = 1'b1; run(3);
      key_raw[0] = 1'b0; run(2);
    end
    check("bounce_no_early_press", press_cnt[0], 0);
    check("bounce_busy_seen", busy_seen, 1'b1);
    key_raw[0] = 1'b1;
    mark();
    run(20);
    check("bounce_press_count", press_cnt[0], 1);
    check("bounce_press_cycle", press_cyc[0] - cyc0, 10);
    key_raw = '0;
    run(15);

    // Release glitch on key 1: 5-cycle drop must be rejected.
    key_raw[1] = 1'b1;
    run(20);
    clear_log();
    key_raw[1] = 1'b0; run(5);
    key_raw[1] = 1'b1; run(20);
    check("glitch_no_release", release_cnt[1], 0);
    check("glitch_no_press", press_cnt[1], 0);
    check("glitch_level", key_level[1], 1'b1);
    key_raw = '0;
    run(15);

    // Async reset four cycles into PRESS_WAIT on key 3.
    key_raw[3] = 1'b1;
    mark();
    run(7);
    check("arst_busy_before", key_busy, 1'b1);
    rst = 1'b1;
    #1;
    model_reset();
    check("arst_level", key_level, 5'b00000);
    check("arst_press", key_press, 5'b00000);
    check("arst_release", key_release, 5'b00000);
    check("arst_busy", key_busy, 1'b0);
    run(3);
    check("arst_no_press", press_cnt[3], 0);
    @(negedge clk);
    rst = 1'b0;
    mark();
    run(15);
    check("arst_press_count", press_cnt[3], 1);
    check("arst_press_cycle", press_cyc[3] - cyc0, 10);
    key_raw = '0;
    run(15);

    // Long hold on key 2 (auto-repeat when enabled).
    key_raw[2] = 1'b1;
    mark();
    run(61);
    check("hold60_press_count", press_cnt[2], HOLD60_PRESSES);
    check("hold60_last_press", press_cyc[2] - cyc0, HOLD60_LAST);
    check("hold60_no_release", release_cnt[2], 0);
    key_raw = '0;
    run(15);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++)
        if ($urandom_range(11) == 0) key_raw[k] = ~key_raw[k];
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
